multi_cycle_control: RTL and testbench
======================================

Name: multi_cycle_control

Overview:
- Sequencing controller for the planned multi-cycle variant of the MIPS processor.
- Replaces the single-cycle combinational main/ALU decode with an FSM that steps a shared datapath through fetch, decode, execute and writeback.
- Drives the instruction-memory handshake, IR/PC/register-file enables, mux selects and the 4-bit ALU operation.
- Supports the same instruction subset: R-type add/addu/sub/subu/and/or/xor/slt/sltu/sll/srl/sra; addi/addiu/andi/ori/xori/slti/sltiu; beq.

Parameters:
- RETIRE_W, 32, width of retired-instruction counter.

Ports:
- CLK  in  1  clock, rising edge.
- Reset_L  in  1  asynchronous, active-low reset.
- imem_ack  in  1  instruction memory has valid data this cycle.
- ir  in  32  instruction register contents (valid from DECODE onward).
- alu_zero  in  1  ALU zero flag.
- imem_req  out  1  fetch request.
- IRWrite  out  1  load IR from memory.
- PCWrite  out  1  load PC.
- PCSrc  out  1  PC source: 0 = ALU result (PC+4), 1 = branch target register.
- ALUSrcA  out  1  ALU input A: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU input B: 0 = reg B, 1 = sign-extended imm, 2 = shamt, 3 = constant 4.
- ALUOp  out  4  ALU operation, shared ALU codes.
- RegDst  out  1  write address: 1 = rd, 0 = rt.
- RegWrite  out  1  register-file write enable.
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode/funct.
- retired  out  RETIRE_W  count of completed instructions.
- state  out  3  current FSM state, exported for debug and verification.

Behaviour:
- Reset (Reset_L low, asynchronous):
  - state = FETCH.
  - All outputs 0, except ALUOp = NOP.
  - retired = 0.
  - Reset asserted mid-instruction abandons it with no write.
- States, fixed encoding: FETCH=0, DECODE=1, EXEC=2, WB=3, BRANCH=4. Codes 5-7 go to FETCH on the next edge.
- FETCH:
  - imem_req=1; ALUSrcA=0, ALUSrcB=3, ALUOp=ADD.
  - No ack: hold state; IRWrite and PCWrite stay 0.
  - imem_ack=1: IRWrite=1, PCWrite=1, PCSrc=0 in the same cycle, then go to DECODE.
  - Ack may arrive the same cycle imem_req first rises.
- DECODE:
  - ALUSrcA=0, ALUSrcB=1, ALUOp=ADD (speculative branch target, latched by the datapath).
  - Supported R/I-type: go to EXEC.
  - beq: go to BRANCH.
  - Otherwise: pulse illegal_instr, go to FETCH. No write, retired unchanged.
- EXEC:
  - ALUSrcA=1.
  - ALUSrcB = 0 for R-type non-shift, 2 for sll/srl/sra, 1 for I-type.
  - ALUOp decoded from opcode/funct (addi=ADD, addiu=ADDU, andi=AND, ori=OR, xori=XOR, slti=SLT, sltiu=SLTU).
  - Next state: WB.
- WB:
  - RegWrite=1; RegDst=1 for R-type, 0 for I-type.
  - Selects and ALUOp held from EXEC.
  - retired increments; next state FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=0, ALUOp=SUB.
  - alu_zero=1: PCWrite=1, PCSrc=1.
  - Always retired+1, RegWrite=0, then FETCH.
  - beq never writes the register file.
- Latency with zero-wait memory: R/I-type 4 cycles, beq 3 cycles, illegal 2 cycles. Each wait cycle in FETCH adds 1.
- retired wraps modulo 2^RETIRE_W, no saturation.
- Control outputs are combinational from state and ir (Moore in state, decoded by ir). Only state and retired are registered.
- ir is read only in DECODE, EXEC, WB and BRANCH. Changes to ir during FETCH are ignored.

Decomposition:
- Shared defines header (already used by the processor) holds:
  - OPCODE_* and FUNCT_* constants.
  - ALU op codes (ADD, ADDU, SUB, SUBU, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, NOP).
  - New state codes and ALUSrcB select codes.
- One sub-module, instr_decode: combinational ir -> {is_rtype, is_shift, is_itype, is_beq, legal, alu_op}.
- The FSM, counter and output logic stay in multi_cycle_control.

Test Plan:
- Reset then release, imem_ack=1 constant, ir=0x00221820 (add $3,$1,$2):
  - states 0,1,2,3 repeat.
  - WB has RegWrite=1, RegDst=1, ALUOp=ADD, ALUSrcB=0.
  - retired=1 after the first WB.
- ir=0x20220005 (addi):
  - EXEC has ALUSrcB=1, ALUOp=ADD.
  - WB has RegDst=0, RegWrite=1.
- ir=0x00021900 (sll $3,$2,4):
  - EXEC has ALUSrcB=2, ALUOp=SLL, ALUSrcA=1.
- ir=0x10220003 (beq):
  - With alu_zero=1 in BRANCH: PCWrite=1, PCSrc=1, RegWrite=0, 3-cycle loop.
  - With alu_zero=0: PCWrite=0.
  - retired increments in both cases.
- imem_ack held low 5 cycles:
  - state stays 0, imem_req=1, IRWrite=0 throughout.
  - Ack on cycle 6 gives one IRWrite pulse.
- ir=0xFC000000 (illegal opcode):
  - illegal_instr pulses one cycle in DECODE, then FETCH; retired unchanged.
- Separately, Reset_L low asynchronously mid-EXEC:
  - all outputs 0 and state=0 immediately, before the next CLK edge.

Source files
------------

// File: rtl/multi_cycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcode/funct
// constants, ALU operation codes, FSM state codes, ALU input-B select codes
// and the packed result of the instruction decoder.
package multi_cycle_control_pkg;

    // Opcodes (ir[31:26])
    localparam logic [5:0] OPCODE_RTYPE = 6'h00;
    localparam logic [5:0] OPCODE_BEQ   = 6'h04;
    localparam logic [5:0] OPCODE_ADDI  = 6'h08;
    localparam logic [5:0] OPCODE_ADDIU = 6'h09;
    localparam logic [5:0] OPCODE_SLTI  = 6'h0A;
    localparam logic [5:0] OPCODE_SLTIU = 6'h0B;
    localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
    localparam logic [5:0] OPCODE_ORI   = 6'h0D;
    localparam logic [5:0] OPCODE_XORI  = 6'h0E;

    // R-type function codes (ir[5:0])
    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    // ALU operation codes shared with the datapath ALU.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_ADDU = 4'h1,
        ALU_SUB  = 4'h2,
        ALU_SUBU = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SRA  = 4'h9,
        ALU_SLT  = 4'hA,
        ALU_SLTU = 4'hB,
        ALU_NOP  = 4'hF
    } alu_op_e;

    // Controller states; encoding is visible on the debug port.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_BRANCH = 3'd4
    } state_e;

    // ALU input-B selects.
    localparam logic [1:0] SRCB_REG   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_SHAMT = 2'd2;
    localparam logic [1:0] SRCB_FOUR  = 2'd3;

    // Decoder result. is_rtype covers only supported R-type functs.
    typedef struct packed {
        logic    is_rtype;
        logic    is_shift;
        logic    is_itype;
        logic    is_beq;
        logic    legal;
        alu_op_e alu_op;
    } decode_t;

endpackage

// File: rtl/multi_cycle_control_if.sv
// Controller <-> datapath/instruction-memory signal bundle.
// master : the controller (drives control outputs, reads status).
// slave  : datapath/memory side (drives imem_ack, ir, alu_zero).
// Inputs to controller : imem_ack, ir[31:0], alu_zero.
// Outputs of controller: imem_req, IRWrite, PCWrite, PCSrc, ALUSrcA,
//   ALUSrcB[1:0], ALUOp[3:0], RegDst, RegWrite, illegal_instr,
//   retired[RETIRE_W-1:0], state[2:0].
interface multi_cycle_control_if #(
    parameter int RETIRE_W = 32
);
    logic                imem_ack;
    logic [31:0]         ir;
    logic                alu_zero;

    logic                imem_req;
    logic                IRWrite;
    logic                PCWrite;
    logic                PCSrc;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [3:0]          ALUOp;
    logic                RegDst;
    logic                RegWrite;
    logic                illegal_instr;
    logic [RETIRE_W-1:0] retired;
    logic [2:0]          state;

    modport master (
        input  imem_ack, ir, alu_zero,
        output imem_req, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
               RegDst, RegWrite, illegal_instr, retired, state
    );

    modport slave (
        output imem_ack, ir, alu_zero,
        input  imem_req, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
               RegDst, RegWrite, illegal_instr, retired, state
    );
endinterface

// File: rtl/multi_cycle_control_instr_decode.sv
// Combinational instruction classifier for the supported MIPS subset.
// Ports:
//   ir_i  [31:0] instruction word
//   dec_o        {is_rtype, is_shift, is_itype, is_beq, legal, alu_op}
module multi_cycle_control_instr_decode
    import multi_cycle_control_pkg::*;
(
    input  logic [31:0] ir_i,
    output decode_t     dec_o
);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_ir;

    assign opcode    = ir_i[31:26];
    assign funct     = ir_i[5:0];
    // Register/immediate fields are the datapath's business, not control's.
    assign unused_ir = ^ir_i[25:6];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        dec_o        = '0;
        dec_o.alu_op = ALU_NOP;
        case (opcode)
            OPCODE_RTYPE: begin
                dec_o.is_rtype = 1'b1;
                dec_o.legal    = 1'b1;
                case (funct)
                    FUNCT_ADD:  dec_o.alu_op = ALU_ADD;
                    FUNCT_ADDU: dec_o.alu_op = ALU_ADDU;
                    FUNCT_SUB:  dec_o.alu_op = ALU_SUB;
                    FUNCT_SUBU: dec_o.alu_op = ALU_SUBU;
                    FUNCT_AND:  dec_o.alu_op = ALU_AND;
                    FUNCT_OR:   dec_o.alu_op = ALU_OR;
                    FUNCT_XOR:  dec_o.alu_op = ALU_XOR;
                    FUNCT_SLT:  dec_o.alu_op = ALU_SLT;
                    FUNCT_SLTU: dec_o.alu_op = ALU_SLTU;
                    FUNCT_SLL: begin dec_o.alu_op = ALU_SLL; dec_o.is_shift = 1'b1; end
                    FUNCT_SRL: begin dec_o.alu_op = ALU_SRL; dec_o.is_shift = 1'b1; end
                    FUNCT_SRA: begin dec_o.alu_op = ALU_SRA; dec_o.is_shift = 1'b1; end
                    default: begin
                        dec_o.is_rtype = 1'b0;
                        dec_o.legal    = 1'b0;
                    end
                endcase
            end
            OPCODE_ADDI:  begin dec_o.is_itype = 1'b1; dec_o.alu_op = ALU_ADD;  end
            OPCODE_ADDIU: begin dec_o.is_itype = 1'b1; dec_o.alu_op = ALU_ADDU; end
            OPCODE_ANDI:  begin dec_o.is_itype = 1'b1; dec_o.alu_op = ALU_AND;  end
            OPCODE_ORI:   begin dec_o.is_itype = 1'b1; dec_o.alu_op = ALU_OR;   end
            OPCODE_XORI:  begin dec_o.is_itype = 1'b1; dec_o.alu_op = ALU_XOR;  end
            OPCODE_SLTI:  begin dec_o.is_itype = 1'b1; dec_o.alu_op = ALU_SLT;  end
            OPCODE_SLTIU: begin dec_o.is_itype = 1'b1; dec_o.alu_op = ALU_SLTU; end
            OPCODE_BEQ: begin
                dec_o.is_beq = 1'b1;
                dec_o.alu_op = ALU_SUB;
            end
            default: ;
        endcase
        if (dec_o.is_itype || dec_o.is_beq) begin
            dec_o.legal = 1'b1;
        end
    end
endmodule

// File: rtl/multi_cycle_control.sv
// Sequencing FSM for the multi-cycle MIPS datapath:
// FETCH -> DECODE -> EXEC -> WB for R/I-type, FETCH -> DECODE -> BRANCH for
// beq, FETCH -> DECODE -> FETCH for unsupported encodings.
// Ports:
//   CLK      rising-edge clock
//   Reset_L  asynchronous active-low reset
//   bus      controller side of multi_cycle_control_if (see that file)
// Only state and retired are registered; all control outputs decode from
// state and ir.
module multi_cycle_control
    import multi_cycle_control_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input logic                    CLK,
    input logic                    Reset_L,
    multi_cycle_control_if.master  bus
);
    state_e              state_q, state_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    decode_t             dec;

    multi_cycle_control_instr_decode u_decode (
        .ir_i  (bus.ir),
        .dec_o (dec)
    );

    always_comb begin
        state_d   = ST_FETCH;
        retired_d = retired_q;
        case (state_q)
            ST_FETCH:  state_d = bus.imem_ack ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (dec.is_beq)     state_d = ST_BRANCH;
                else if (dec.legal) state_d = ST_EXEC;
                else                state_d = ST_FETCH;
            end
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     retired_d = retired_q + RETIRE_W'(1);
            ST_BRANCH: retired_d = retired_q + RETIRE_W'(1);
            default:   state_d = ST_FETCH;  // stray codes recover to FETCH
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!Reset_L) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Outputs are gated by Reset_L directly so that an asynchronous reset
    // silences every enable at once, not just at the next edge.
    always_comb begin
        bus.imem_req      = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.PCWrite       = 1'b0;
        bus.PCSrc         = 1'b0;
        bus.ALUSrcA       = 1'b0;
        bus.ALUSrcB       = SRCB_REG;
        bus.ALUOp         = ALU_NOP;
        bus.RegDst        = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.illegal_instr = 1'b0;
        if (Reset_L) begin
            case (state_q)
                ST_FETCH: begin
                    bus.imem_req = 1'b1;
                    bus.ALUSrcB  = SRCB_FOUR;
                    bus.ALUOp    = ALU_ADD;
                    bus.IRWrite  = bus.imem_ack;
                    bus.PCWrite  = bus.imem_ack;
                end
                ST_DECODE: begin
                    // Speculative branch target: PC+4 + sign-extended offset.
                    bus.ALUSrcB       = SRCB_IMM;
                    bus.ALUOp         = ALU_ADD;
                    bus.illegal_instr = !dec.legal;
                end
                ST_EXEC, ST_WB: begin
                    bus.ALUSrcA  = 1'b1;
                    bus.ALUSrcB  = dec.is_shift ? SRCB_SHAMT :
                                   dec.is_itype ? SRCB_IMM : SRCB_REG;
                    bus.ALUOp    = dec.alu_op;
                    bus.RegDst   = dec.is_rtype;
                    bus.RegWrite = (state_q == ST_WB);
                end
                ST_BRANCH: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = SRCB_REG;
                    bus.ALUOp   = ALU_SUB;
                    bus.PCWrite = bus.alu_zero;
                    bus.PCSrc   = bus.alu_zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.state   = state_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control. An instruction-level model
// tracks "cycles since the fetch was accepted" and the instruction class, and
// a per-cycle compare process checks every output against it. Directed
// scenarios additionally pin literal values taken from the per-cycle trace.
module tb_multi_cycle_control;
    localparam int RW = 4;  // narrow counter so the wrap is exercised

    typedef enum {K_RTYPE, K_ITYPE, K_BEQ, K_ILLEGAL} kind_t;
    typedef struct {
        kind_t      kind;
        logic [3:0] op;
        logic [1:0] srcb;
    } info_t;
    typedef struct packed {
        logic [2:0] state;
        logic       req, irw, pcw, pcsrc, srca;
        logic [1:0] srcb;
        logic [3:0] op;
        logic       regdst, regw, ill;
    } outs_t;

    logic CLK = 1'b0;
    logic Reset_L;
    int   n_checks = 0;
    int   n_err    = 0;
    bit   cmp_en   = 1'b0;
    outs_t trace[$];

    // model state
    bit          m_busy;
    int          m_el;
    kind_t       m_kind;
    logic [RW-1:0] m_ret;

    logic [5:0] rfun_tab [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                  6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
    logic [5:0] iop_tab  [7]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};

    multi_cycle_control_if #(.RETIRE_W(RW)) bus ();

    multi_cycle_control #(.RETIRE_W(RW)) dut (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU codes: ADD 0, ADDU 1, SUB 2, SUBU 3, AND 4, OR 5, XOR 6, SLL 7,
    // SRL 8, SRA 9, SLT A, SLTU B, NOP F.
    function automatic info_t classify(input logic [31:0] w);
        info_t r;
        r.kind = K_ILLEGAL; r.op = 4'hF; r.srcb = 2'd0;
        if (w[31:26] == 6'h00) begin
            r.kind = K_RTYPE;
            case (w[5:0])
                6'h20: r.op = 4'h0;
                6'h21: r.op = 4'h1;
                6'h22: r.op = 4'h2;
                6'h23: r.op = 4'h3;
                6'h24: r.op = 4'h4;
                6'h25: r.op = 4'h5;
                6'h26: r.op = 4'h6;
                6'h2A: r.op = 4'hA;
                6'h2B: r.op = 4'hB;
                6'h00: begin r.op = 4'h7; r.srcb = 2'd2; end
                6'h02: begin r.op = 4'h8; r.srcb = 2'd2; end
                6'h03: begin r.op = 4'h9; r.srcb = 2'd2; end
                default: r.kind = K_ILLEGAL;
            endcase
        end else begin
            r.kind = K_ITYPE; r.srcb = 2'd1;
            case (w[31:26])
                6'h08: r.op = 4'h0;
                6'h09: r.op = 4'h1;
                6'h0A: r.op = 4'hA;
                6'h0B: r.op = 4'hB;
                6'h0C: r.op = 4'h4;
                6'h0D: r.op = 4'h5;
                6'h0E: r.op = 4'h6;
                6'h04: begin r.kind = K_BEQ; r.srcb = 2'd0; end
                default: begin r.kind = K_ILLEGAL; r.srcb = 2'd0; end
            endcase
        end
        return r;
    endfunction

    // Model: an accepted fetch starts an instruction; its class decides how
    // many further cycles it occupies and when it retires.
    always @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            m_busy <= 1'b0;
            m_el   <= 0;
            m_ret  <= '0;
        end else if (!m_busy) begin
            if (bus.imem_ack) begin
                m_busy <= 1'b1;
                m_el   <= 1;
            end
        end else begin
            case (m_el)
                1: begin
                    m_kind <= classify(bus.ir).kind;
                    if (classify(bus.ir).kind == K_ILLEGAL) m_busy <= 1'b0;
                    else m_el <= 2;
                end
                2: begin
                    if (m_kind == K_BEQ) begin
                        m_ret  <= m_ret + 1'b1;
                        m_busy <= 1'b0;
                    end else m_el <= 3;
                end
                default: begin
                    m_ret  <= m_ret + 1'b1;
                    m_busy <= 1'b0;
                end
            endcase
        end
    end

    function automatic outs_t expect_outs();
        outs_t e;
        info_t inf;
        e = '0;
        e.op = 4'hF;
        inf = classify(bus.ir);
        if (Reset_L !== 1'b1) return e;
        if (!m_busy) begin
            e.req = 1'b1; e.srcb = 2'd3; e.op = 4'h0;
            e.irw = bus.imem_ack; e.pcw = bus.imem_ack;
        end else if (m_el == 1) begin
            e.state = 3'd1; e.srcb = 2'd1; e.op = 4'h0;
            e.ill = (inf.kind == K_ILLEGAL);
        end else if (m_el == 2 && m_kind == K_BEQ) begin
            e.state = 3'd4; e.srca = 1'b1; e.op = 4'h2;
            e.pcw = bus.alu_zero; e.pcsrc = bus.alu_zero;
        end else begin
            e.state = (m_el == 2) ? 3'd2 : 3'd3;
            e.srca = 1'b1; e.srcb = inf.srcb; e.op = inf.op;
            e.regdst = (inf.kind == K_RTYPE);
            e.regw = (m_el == 3);
        end
        return e;
    endfunction

    always @(negedge CLK) begin
        if (cmp_en) begin : cmp
            outs_t a, e;
            a = '{state: bus.state, req: bus.imem_req, irw: bus.IRWrite,
                  pcw: bus.PCWrite, pcsrc: bus.PCSrc, srca: bus.ALUSrcA,
                  srcb: bus.ALUSrcB, op: bus.ALUOp, regdst: bus.RegDst,
                  regw: bus.RegWrite, ill: bus.illegal_instr};
            e = expect_outs();
            trace.push_back(a);
            check("state",         32'(a.state),  32'(e.state));
            check("imem_req",      32'(a.req),    32'(e.req));
            check("IRWrite",       32'(a.irw),    32'(e.irw));
            check("PCWrite",       32'(a.pcw),    32'(e.pcw));
            check("PCSrc",         32'(a.pcsrc),  32'(e.pcsrc));
            check("ALUSrcA",       32'(a.srca),   32'(e.srca));
            check("ALUSrcB",       32'(a.srcb),   32'(e.srcb));
            check("ALUOp",         32'(a.op),     32'(e.op));
            check("RegDst",        32'(a.regdst), 32'(e.regdst));
            check("RegWrite",      32'(a.regw),   32'(e.regw));
            check("illegal_instr", 32'(a.ill),    32'(e.ill));
            check("retired",       32'(bus.retired), 32'(m_ret));
        end
    end

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    // Starts at posedge+1 of a FETCH cycle; returns at posedge+1 of the next
    // FETCH cycle. trace holds one entry per cycle of this instruction.
    task automatic exec_instr(input logic [31:0] w, input int waits, input logic z);
        int guard;
        trace.delete();
        for (int i = 0; i < waits; i++) begin
            bus.imem_ack = 1'b0; bus.ir = $urandom; bus.alu_zero = 1'($urandom);
            nxt();
        end
        bus.imem_ack = 1'b1; bus.ir = $urandom; bus.alu_zero = 1'($urandom);
        nxt();
        guard = 0;
        while (m_busy && guard < 8) begin
            bus.ir = w; bus.alu_zero = z; bus.imem_ack = 1'($urandom);
            nxt();
            guard++;
        end
        check("instr_done", 32'(m_busy), 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int sel;
        w = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 4) begin
            w[31:26] = 6'h00;
            w[5:0] = rfun_tab[$urandom_range(0, 11)];
        end else if (sel < 7) begin
            w[31:26] = iop_tab[$urandom_range(0, 6)];
        end else if (sel == 7) begin
            w[31:26] = 6'h04;
        end else if (sel == 8) begin
            if (classify(w).kind != K_ILLEGAL) w[31:26] = 6'h3F;
        end else begin
            w[31:26] = 6'h00;
            if (classify(w).kind != K_ILLEGAL) w[5:0] = 6'h3F;
        end
        return w;
    endfunction

    localparam logic [31:0] ADD_W  = 32'h0022_1820;
    localparam logic [31:0] ADDI_W = 32'h2022_0005;
    localparam logic [31:0] SLL_W  = 32'h0002_1900;
    localparam logic [31:0] BEQ_W  = 32'h1022_0003;
    localparam logic [31:0] ILL_W  = 32'hFC00_0000;

    initial begin
        Reset_L = 1'b0;
        bus.imem_ack = 1'b1; bus.ir = ADD_W; bus.alu_zero = 1'b0;
        nxt();
        cmp_en = 1'b1;
        @(negedge CLK);
        check("rst_state",    32'(bus.state),    32'd0);
        check("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check("rst_aluop",    32'(bus.ALUOp),    32'hF);
        check("rst_retired",  32'(bus.retired),  32'd0);
        nxt();
        Reset_L = 1'b1;

        // add, zero-wait: 0,1,2,3 repeating
        for (int n = 0; n < 3; n++) begin
            exec_instr(ADD_W, 0, 1'b0);
            check("add_len", 32'(trace.size()), 32'd4);
            for (int k = 0; k < 4; k++) check("add_seq_state", 32'(trace[k].state), 32'(k));
            check("add_fetch_irw", 32'(trace[0].irw), 32'd1);
            check("add_wb_regw",   32'(trace[3].regw), 32'd1);
            check("add_wb_regdst", 32'(trace[3].regdst), 32'd1);
            check("add_wb_aluop",  32'(trace[3].op), 32'h0);
            check("add_wb_srcb",   32'(trace[3].srcb), 32'd0);
            check("add_retired",   32'(bus.retired), 32'(n + 1));
        end

        exec_instr(ADDI_W, 0, 1'b0);
        check("addi_ex_srcb",   32'(trace[2].srcb), 32'd1);
        check("addi_ex_aluop",  32'(trace[2].op), 32'h0);
        check("addi_wb_regdst", 32'(trace[3].regdst), 32'd0);
        check("addi_wb_regw",   32'(trace[3].regw), 32'd1);
        check("addi_retired",   32'(bus.retired), 32'd4);

        exec_instr(SLL_W, 0, 1'b0);
        check("sll_ex_srcb",  32'(trace[2].srcb), 32'd2);
        check("sll_ex_aluop", 32'(trace[2].op), 32'h7);
        check("sll_ex_srca",  32'(trace[2].srca), 32'd1);
        check("sll_retired",  32'(bus.retired), 32'd5);

        exec_instr(BEQ_W, 0, 1'b1);
        check("beq_t_len",   32'(trace.size()), 32'd3);
        check("beq_t_state", 32'(trace[2].state), 32'd4);
        check("beq_t_pcw",   32'(trace[2].pcw), 32'd1);
        check("beq_t_pcsrc", 32'(trace[2].pcsrc), 32'd1);
        check("beq_t_regw",  32'(trace[2].regw), 32'd0);
        check("beq_t_ret",   32'(bus.retired), 32'd6);

        exec_instr(BEQ_W, 0, 1'b0);
        check("beq_nt_pcw", 32'(trace[2].pcw), 32'd0);
        check("beq_nt_ret", 32'(bus.retired), 32'd7);

        exec_instr(ADD_W, 5, 1'b0);
        check("wait_len", 32'(trace.size()), 32'd9);
        for (int k = 0; k < 5; k++) begin
            check("wait_state", 32'(trace[k].state), 32'd0);
            check("wait_req",   32'(trace[k].req), 32'd1);
            check("wait_irw",   32'(trace[k].irw), 32'd0);
        end
        check("wait_ack_irw", 32'(trace[5].irw), 32'd1);
        check("wait_ret",     32'(bus.retired), 32'd8);

        exec_instr(ILL_W, 0, 1'b0);
        check("ill_len",     32'(trace.size()), 32'd2);
        check("ill_fetch",   32'(trace[0].ill), 32'd0);
        check("ill_pulse",   32'(trace[1].ill), 32'd1);
        check("ill_regw",    32'(trace[1].regw), 32'd0);
        check("ill_state",   32'(bus.state), 32'd0);
        check("ill_retired", 32'(bus.retired), 32'd8);

        // asynchronous reset in the middle of EXEC
        bus.imem_ack = 1'b1; bus.ir = $urandom;
        nxt();
        bus.ir = ADD_W;
        nxt();
        #2;
        check("pre_rst_state", 32'(bus.state), 32'd2);
        Reset_L = 1'b0;
        #1;
        check("arst_state",    32'(bus.state), 32'd0);
        check("arst_req",      32'(bus.imem_req), 32'd0);
        check("arst_srca",     32'(bus.ALUSrcA), 32'd0);
        check("arst_srcb",     32'(bus.ALUSrcB), 32'd0);
        check("arst_aluop",    32'(bus.ALUOp), 32'hF);
        check("arst_regw",     32'(bus.RegWrite), 32'd0);
        check("arst_regdst",   32'(bus.RegDst), 32'd0);
        check("arst_retired",  32'(bus.retired), 32'd0);
        nxt();
        nxt();
        Reset_L = 1'b1;

        // 17 retirements wrap a 4-bit counter to 1
        for (int n = 0; n < 17; n++) exec_instr(ADD_W, $urandom_range(0, 2), 1'b0);
        check("wrap_retired", 32'(bus.retired), 32'd1);

        for (int n = 0; n < 300; n++) begin
            exec_instr(rand_instr(), $urandom_range(0, 3), 1'($urandom));
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
